// File: rtl/simon_host_driver.sv
// simon_host_driver: host valid/ready front end sequencing key and block loads through a SIMON 96/144 core; SIMON_DRV_TIMEOUT_EN adds a watchdog
module simon_host_driver #(
    parameter int N      = 48,
    parameter int M      = 3,
    parameter int TO_CYC = 1024
) (
    input  logic             clk,
    input  logic             R,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2*N-1:0]   req_block,
    input  logic             req_enc,
    input  logic             req_kload,
    input  logic [M*N-1:0]   req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*N-1:0]   rsp_block,
    output logic             err,
    output logic             newData,
    output logic             newKey,
    output logic             readData,
    output logic             enc_dec,
    output logic [2*N-1:0]   plain,
    output logic [M*N-1:0]   key,
    input  logic             ldData,
    input  logic             ldKey,
    input  logic             doneData,
    input  logic             doneKey,
    input  logic [2*N-1:0]   cipher
);
    typedef enum logic [2:0] {IDLE, KREQ, KWAIT, DREQ, DRUN, READ, RSP, ERR} state_t;
    state_t           state_q, state_d;
    logic             key_ok_q, key_ok_d;
    logic             enc_q, enc_d;
    logic [2*N-1:0]   plain_q, plain_d;
    logic [2*N-1:0]   rsp_q, rsp_d;
    logic [M*N-1:0]   key_q, key_d;
    logic [4:0]       ctl_q, ctl_d;
`ifdef SIMON_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             waiting;
`endif

    // next state, latched transaction data and registered handshake controls
    always_comb begin
        state_d  = state_q;
        key_ok_d = key_ok_q;
        enc_d    = enc_q;
        plain_d  = plain_q;
        key_d    = key_q;
        rsp_d    = rsp_q;
        case (state_q)
            IDLE: if (req_valid && ctl_q[4]) begin
                plain_d = req_block;
                enc_d   = req_enc;
                key_d   = req_key;
                state_d = (req_kload || !key_ok_q) ? KREQ : DREQ;
            end
            KREQ:  state_d = ldKey ? KWAIT : KREQ;
            KWAIT: if (doneKey) begin
                key_ok_d = 1'b1;
                state_d  = DREQ;
            end
            DREQ:  state_d = ldData ? DRUN : DREQ;
            DRUN:  if (doneData) begin
                rsp_d   = cipher;
                state_d = READ;
            end
            READ:  state_d = doneData ? READ : RSP;
            RSP:   state_d = rsp_ready ? IDLE : RSP;
            ERR:   key_ok_d = 1'b0;
        endcase
`ifdef SIMON_DRV_TIMEOUT_EN
        waiting = state_q inside {KREQ, KWAIT, DREQ, DRUN, READ};
        if (waiting && cnt_q == CW'(TO_CYC - 1)) begin
            state_d  = ERR;
            key_ok_d = 1'b0;
        end
        cnt_d = (state_d != state_q || !waiting) ? '0 : cnt_q + 1'b1;
        err_d = state_d == ERR;
`endif
        ctl_d = {state_d == IDLE, state_d == KREQ, state_d == DREQ, state_d == READ, state_d == RSP};
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (R) begin
            state_q  <= IDLE;
            key_ok_q <= 1'b0;
            enc_q    <= 1'b0;
            plain_q  <= '0;
            key_q    <= '0;
            rsp_q    <= '0;
            ctl_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_ok_q <= key_ok_d;
            enc_q    <= enc_d;
            plain_q  <= plain_d;
            key_q    <= key_d;
            rsp_q    <= rsp_d;
            ctl_q    <= ctl_d;
        end
    end

`ifdef SIMON_DRV_TIMEOUT_EN
    // watchdog counter and sticky error
    always_ff @(posedge clk) begin
        if (R) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign {req_ready, newKey, newData, readData, rsp_valid} = ctl_q;
    assign enc_dec   = enc_q;
    assign plain     = plain_q;
    assign key       = key_q;
    assign rsp_block = rsp_q;
endmodule

// File: tb/tb_simon_host_driver.sv
// tb_simon_host_driver: directed bench with a behavioural SIMON core and a transaction-level driver model
module tb_simon_host_driver;
    localparam logic [143:0] KEY = 144'h1514131211100D0C0B0A0908050403020100;
    localparam logic [95:0]  PT  = 96'h74616874207473756420666f;
    localparam logic [95:0]  CT  = 96'hECAD1C6C451E3f59C5DB1AE9;
    localparam logic [143:0] K2  = {48'hA5A5A5A5A5A5, 96'h0};
    localparam logic [95:0]  B2  = 96'h0123456789ABCDEF01234567;

    logic clk = 0, R = 1;
    logic req_valid = 0, req_enc = 0, req_kload = 0, rsp_ready = 0;
    logic [95:0] req_block = '0;
    logic [143:0] req_key = '0;
    logic req_ready, rsp_valid, err, newData, newKey, readData, enc_dec;
    logic [95:0] rsp_block, plain, cipher;
    logic [143:0] key;
    logic ldData, ldKey, doneData, doneKey;

    int total = 0, bad = 0;
    logic mon_en = 0, txn = 0, saw_nk = 0, exp_kload = 0, exp_enc = 0, m_key_ok = 0;
    logic [95:0] exp_plain = '0, exp_rsp = '0;
    logic [143:0] exp_key = '0, m_core_key = '0;
    logic p_nk = 0, p_lk = 0, p_nd = 0, p_ld = 0, p_rd = 0, p_dd = 0;

    always #5 clk = ~clk;

    simon_host_driver #(.TO_CYC(1024)) dut (
        .clk(clk), .R(R), .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block),
        .req_enc(req_enc), .req_kload(req_kload), .req_key(req_key), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_block(rsp_block), .err(err), .newData(newData), .newKey(newKey),
        .readData(readData), .enc_dec(enc_dec), .plain(plain), .key(key), .ldData(ldData),
        .ldKey(ldKey), .doneData(doneData), .doneKey(doneKey), .cipher(cipher)
    );

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // core behaviour: known SIMON 96/144 vector pair, otherwise a simple keyed transform
    function automatic logic [95:0] core_f(input logic [95:0] b, input logic e, input logic [143:0] k);
        if (k == KEY && e && b == PT) return CT;
        if (k == KEY && !e && b == CT) return PT;
        return b ^ k[95:0] ^ {96{e}};
    endfunction

    // behavioural core: 3-cycle load acks, ~54-cycle run, doneData held until readData
    int kcnt, dcnt;
    logic [143:0] core_key;
    logic [95:0] res;
    always @(posedge clk) begin
        ldKey <= 1'b0;
        doneKey <= 1'b0;
        ldData <= 1'b0;
        if (R) begin
            kcnt <= 0; dcnt <= 0; doneData <= 1'b0; cipher <= '0; core_key <= '0; res <= '0;
        end else begin
            if (kcnt != 0 || newKey) kcnt <= (kcnt == 7) ? 0 : kcnt + 1;
            if (kcnt == 2) begin ldKey <= 1'b1; core_key <= key; end
            if (kcnt == 7) doneKey <= 1'b1;
            if (dcnt == 0) begin
                if (newData) dcnt <= 1;
            end else if (dcnt < 56) begin
                dcnt <= dcnt + 1;
                if (dcnt == 2) begin ldData <= 1'b1; res <= core_f(plain, enc_dec, core_key); end
                if (dcnt == 55) begin doneData <= 1'b1; cipher <= res; end
            end else if (readData) begin
                doneData <= 1'b0;
                dcnt <= 0;
            end
        end
    end

    // per-cycle compare of driver outputs against the transaction model and handshake rules
    always @(negedge clk) begin
        if (mon_en && !R) begin
            if (txn) begin
                check("plain", plain, exp_plain);
                check("key", key, exp_key);
                check("enc_dec", enc_dec, exp_enc);
            end
            if (rsp_valid) check("rsp_block", rsp_block, exp_rsp);
            check("one_hot", $countones({req_ready, newKey, newData, readData, rsp_valid}) <= 1, 1);
            check("err", err, 0);
            if (p_nk) check("newkey_hs", newKey, !p_lk);
            if (p_nd) check("newdata_hs", newData, !p_ld);
            if (p_rd) check("readdata_hs", {readData, rsp_valid}, {p_dd, !p_dd});
            if (newKey) saw_nk = 1;
            {p_nk, p_lk, p_nd, p_ld, p_rd, p_dd} = {newKey, ldKey, newData, ldData, readData, doneData};
        end else begin
            {p_nk, p_lk, p_nd, p_ld, p_rd, p_dd} = '0;
        end
    end

    task automatic send(input logic [95:0] b, input logic e, input logic k, input logic [143:0] kv);
        int n = 0;
        @(posedge clk); #1;
        req_block = b; req_enc = e; req_kload = k; req_key = kv; req_valid = 1;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_timeout", req_ready, 1);
        @(posedge clk); #1 req_valid = 0;
        exp_kload = k || !m_key_ok;
        if (exp_kload) m_core_key = kv;
        m_key_ok = 1;
        exp_plain = b; exp_key = kv; exp_enc = e;
        exp_rsp = core_f(b, e, m_core_key);
        saw_nk = 0;
        txn = 1;
    endtask

    task automatic finish(input int hold, output logic [95:0] got);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
        check("rsp_timeout", rsp_valid, 1);
        got = rsp_block;
        repeat (hold) begin
            check("bp_hold", {rsp_valid, req_ready}, 2'b10);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        check("rsp_drop", {rsp_valid, req_ready}, 2'b01);
        check("newkey_seen", saw_nk, exp_kload);
    endtask

`ifdef SIMON_DRV_TIMEOUT_EN
    logic r2 = 1, rv2 = 0;
    logic rr2, rsp_valid2, err2, nd2, nk2, rd2, ed2;
    logic [95:0] rsp_block2, plain2;
    logic [143:0] key2;
    simon_host_driver #(.TO_CYC(16)) dut2 (
        .clk(clk), .R(r2), .req_valid(rv2), .req_ready(rr2), .req_block(PT), .req_enc(1'b1),
        .req_kload(1'b0), .req_key(KEY), .rsp_valid(rsp_valid2), .rsp_ready(1'b1),
        .rsp_block(rsp_block2), .err(err2), .newData(nd2), .newKey(nk2), .readData(rd2),
        .enc_dec(ed2), .plain(plain2), .key(key2), .ldData(1'b0), .ldKey(nk2),
        .doneData(1'b0), .doneKey(1'b1), .cipher(96'h0)
    );
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] got;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {req_ready, rsp_valid, err, newData, newKey, readData, enc_dec}, 0);
        check("rst_data", {rsp_block, plain}, 0);
        check("rst_key", key, 0);
        @(posedge clk); #1 R = 0;
        mon_en = 1;

        send(PT, 1, 0, KEY); finish(0, got);
        check("first_ct", got, CT);
        check("first_nk", saw_nk, 1);

        send(PT, 1, 1, KEY); finish(0, got);
        check("enc_ct", got, CT);
        check("enc_nk", saw_nk, 1);

        send(CT, 0, 0, KEY); finish(0, got);
        check("dec_pt", got, PT);
        check("dec_nk", saw_nk, 0);

        send(PT, 1, 0, KEY); finish(20, got);
        check("bp_ct", got, CT);

        send(B2, 1, 1, K2); finish(0, got);
        check("k2_enc", got, 96'hFEDCBA9876543210FEDCBA98);
        send(B2, 0, 0, K2); finish(2, got);
        check("k2_dec", got, 96'h0123456789ABCDEF01234567);
        check("k2_dec_nk", saw_nk, 0);

        send(PT, 1, 1, KEY); finish(0, got);
        check("reload_ct", got, CT);

        send(PT, 1, 0, KEY);
        n = 0;
        while (!newData && n < 50) begin @(negedge clk); n++; end
        check("dreq_seen", newData, 1);
        while (newData && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(posedge clk);
        #1 R = 1;
        txn = 0; m_key_ok = 0; m_core_key = '0;
        @(posedge clk); #1 R = 0;
        @(negedge clk);
        check("rr_ctl", {req_ready, rsp_valid, err, newData, newKey, readData, enc_dec}, 0);
        check("rr_data", {rsp_block, plain}, 0);
        check("rr_key", key, 0);
        @(negedge clk);
        check("rr_idle", req_ready, 1);
        send(PT, 1, 0, KEY); finish(0, got);
        check("rr_ct", got, CT);
        check("rr_nk", saw_nk, 1);

`ifdef SIMON_DRV_TIMEOUT_EN
        repeat (2) @(posedge clk);
        #1 r2 = 0;
        rv2 = 1;
        n = 0;
        @(negedge clk);
        while (!rr2 && n < 10) begin @(negedge clk); n++; end
        check("to_accept", rr2, 1);
        @(posedge clk); #1 rv2 = 0;
        n = 0;
        while (!nd2 && n < 20) begin @(negedge clk); n++; end
        check("to_dreq", nd2, 1);
        n = 0;
        while (!err2 && n < 100) begin @(negedge clk); n++; end
        check("to_cycles", n, 16);
        check("to_ctl", {nd2, nk2, rd2, rr2, rsp_valid2}, 0);
        repeat (5) @(negedge clk);
        check("to_sticky", {err2, nd2, rr2}, 3'b100);
        @(posedge clk); #1 r2 = 1;
        @(posedge clk); #1 r2 = 0;
        @(negedge clk);
        check("to_clear", err2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
